// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - multiplexed 7-segment scan controller with blanking and frame-aligned commit
// Walks a one-hot anode across NDIG digits; new words land in a shadow and commit at frame end.
module display_scan_ctrl #(
  parameter int NDIG     = 2,
  parameter int TICK_DIV = 24000,
  parameter int BLANK    = 240
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_valid,
  input  logic [4*NDIG-1:0]   wr_data,
  output logic                wr_ready,
  output logic [3:0]          digit,
  output logic [NDIG-1:0]     anode,
  output logic                frame_start
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(NDIG - 1);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [4*NDIG-1:0] active_q, active_d;
  logic [4*NDIG-1:0] shadow_q, shadow_d;
  logic              pending_q, pending_d;
  logic              slot_end, frame_end, lit;

  // With no blanking the comparison would be constant-true, so skip it outright.
  generate
    if (BLANK == 0) begin : g_no_blank
      assign lit = 1'b1;
    end else begin : g_blank
      assign lit = (cnt_q >= CW'(BLANK));
    end
  endgenerate

  always_comb begin
    cnt_d     = cnt_q + CW'(1);
    ptr_d     = ptr_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    slot_end  = (cnt_q == CNT_LAST);
    frame_end = slot_end && (ptr_q == PTR_LAST);
    if (slot_end) begin
      cnt_d = '0;
      ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PW'(1);
    end
    // Commit needs pending set and accept needs it clear, so they cannot collide.
    if (frame_end && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end else if (wr_valid && !pending_q) begin
      shadow_d  = wr_data;
      pending_d = 1'b1;
    end
  end

  always_comb begin
    anode = '0;
    digit = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (ptr_q == PW'(i)) begin
        anode[i] = lit;
        digit    = active_q[4*i +: 4];
      end
    end
    frame_start = (cnt_q == '0) && (ptr_q == '0);
    wr_ready    = !pending_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      ptr_q     <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Scan controller for the multiplexed 7-segment display in the music transcriber. It owns the digit-select timing: it walks a one-hot anode enable across NDIG digits at a fixed slot rate and inserts an all-off blanking interval before each digit to suppress ghosting. It presents the active digit's 4-bit code to the downstream hex/note segment decoder. New display values arrive on a valid/ready port into a shadow register and are committed only at frame boundaries, so a value never tears mid-frame.

## Interface
Parameters:
- NDIG, 2: number of digits scanned; ≥1.
- TICK_DIV, 24000: clock cycles per digit slot; ≥2.
- BLANK, 240: all-anodes-off cycles at the start of each slot; 0 ≤ BLANK < TICK_DIV.

Ports:
- clk  in  1  system clock. One clock domain; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high reset.
- wr_valid  in  1  producer has a new display word.
- wr_data  in  4*NDIG  display word; digit i is wr_data[4i+3:4i].
- wr_ready  out  1  shadow register empty; a write is accepted on an edge where wr_valid && wr_ready.
- digit  out  4  code of the current slot's digit, to the segment decoder.
- anode  out  NDIG  one-hot digit enable, active-high (1 = digit lit); all zero during blanking.
- frame_start  out  1  high during the first cycle of slot 0.

## Operation
- State registers:
  - cnt: 0..TICK_DIV-1, slot cycle counter.
  - ptr: 0..NDIG-1, current digit.
  - active[4*NDIG]: committed display word.
  - shadow[4*NDIG]: pending display word.
  - pending: 1 bit.
- Outputs are combinational decodes of the registered state:
  - anode[ptr] = (cnt >= BLANK); all other anode bits are 0.
  - digit = active[4*ptr +: 4], including during blanking, so the decoder settles before the anode turns on.
  - frame_start = (cnt==0 && ptr==0).
  - wr_ready = !pending.
- Counting:
  - cnt increments every cycle.
  - At cnt==TICK_DIV-1, cnt wraps to 0 and ptr advances.
  - ptr wraps from NDIG-1 to 0.
- Phases per slot: BLANK (cnt < BLANK), then ON (cnt ≥ BLANK). If BLANK==0, there is no blank phase.
- Write accept: on an edge with wr_valid && !pending, shadow <= wr_data and pending <= 1.
- Commit: on the edge where cnt==TICK_DIV-1, ptr==NDIG-1 and pending==1 (registered value), active <= shadow and pending <= 0.
- Commit and accept are never simultaneous, because accept requires pending==0.
- A write accepted on the frame-boundary edge itself is not committed on that edge. It becomes pending and commits at the next boundary.
- While pending==1, wr_valid is ignored. The producer must hold wr_valid and wr_data until accepted.

## Timing
- Reset values, visible in the cycle after the reset edge and held while reset is high:
  - cnt=0, ptr=0, active=0, shadow=0, pending=0.
  - anode = 0 (if BLANK>0; else anode[0]=1).
  - digit = 0, wr_ready = 1, frame_start = 1.
- Reset asserted mid-frame: all state returns to the reset values on that edge, and any pending word is discarded.
- Slot period = TICK_DIV cycles; frame period = NDIG*TICK_DIV cycles.
- Lit cycles per slot = TICK_DIV-BLANK.
- At most one anode bit is high in any cycle, and at least BLANK all-zero cycles separate consecutive lit digits.
- Write latency:
  - wr_ready falls in the cycle after accept.
  - The new value appears on digit from the first cycle of the next frame (the cycle with frame_start=1).
  - wr_ready rises in that same cycle.

## Test plan
Parameters for all scenarios: NDIG=2, TICK_DIV=10, BLANK=2. Cycle 0 is the first cycle after reset is released.
- **Reset:** hold reset 3 cycles → anode=00, digit=0, wr_ready=1, frame_start=1 throughout; cycle 0 also matches.
- **Free scan, no writes:**
  - anode=00 at cycles 0–1, 01 at 2–9, 00 at 10–11, 10 at 12–19; the pattern repeats with period 20.
  - frame_start=1 only at cycles 0, 20, 40.
  - Never two anode bits high.
- **Write mid-frame:** wr_valid=1, wr_data=0x5A at cycle 3 →
  - wr_ready=0 at cycles 4–19 and digit=0 until cycle 19.
  - digit=0xA at cycles 20–29, digit=0x5 at 30–39.
  - wr_ready=1 at cycle 20.
- **Write held while pending:**
  - Accept 0x12 at cycle 3, then hold wr_valid with 0x34 → 0x34 is accepted at cycle 20.
  - Frame 20–39 shows 2,1; frame 40–59 shows 4,3.
- **Write on boundary edge:** accept 0x77 on the cycle-19 edge → cycles 20–39 still show the old value, wr_ready=0; cycles 40–59 show 7,7.
- **Reset mid-operation:** accept 0x99 at cycle 5, assert reset at cycle 12 for one cycle →
  - Outputs return to the reset values.
  - Digit stays 0 through the next full frame.
  - wr_ready=1.
